synth_voice_mixer: RTL

Parametrised successor to the synth top-level's subsample accumulator. Takes per-voice subsamples from the core, applies a register-programmed per-voice gain, and sums one frame into a sample. The result is scaled, saturated and queued in an output FIFO with a valid/ready handshake. It sits between the core and the DAC/PWM output stage and shares the 16-bit register write bus.

---
 rtl/synth_voice_mixer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/synth_voice_mixer.sv
// Per-voice gain, frame accumulation, scale/saturate and output FIFO for the synth core.
// Optional register readback mux enabled by defining SYNTH_MIXER_READBACK_EN.
module synth_voice_mixer #(
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned SUB_W      = 16,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned OUT_SHIFT  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic signed [SUB_W-1:0]       i_Subsample,
    input  logic [$clog2(NUM_VOICES)-1:0] i_SubsampleVoice,
    input  logic                          i_SubsampleValid,
    input  logic                          i_FrameEnd,
    input  logic [15:0]                   i_RegisterNumber,
    input  logic [15:0]                   i_RegisterValue,
    input  logic                          i_RegisterWriteEnable,
    output logic signed [OUT_W-1:0]       o_Sample,
    output logic                          o_SampleValid,
    input  logic                          i_SampleReady,
    output logic                          o_Clipped,
    output logic                          o_Overflow,
    output logic [15:0]                   o_RegisterReadData
);

    localparam int unsigned VW     = $clog2(NUM_VOICES);
    localparam int unsigned NG     = 1 << VW;
    localparam int unsigned PROD_W = SUB_W + 1;
    localparam int unsigned MULT_W = SUB_W + 10;
    localparam int unsigned ACC_W  = SUB_W + VW + 1;
    localparam int unsigned CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam logic [8:0]  UNITY  = 9'd256;
    localparam logic signed [CMP_W-1:0] SAT_MAX = CMP_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CMP_W-1:0] SAT_MIN = ~SAT_MAX;

    // Register write decode
    logic           gain_we;
    logic           ctrl_we;
    logic           clr_we;
    logic [VW-1:0]  gain_idx;
    logic [8:0]     gain_val;

    assign gain_we  = i_RegisterWriteEnable && (i_RegisterNumber[15:8] == 8'h00)
                      && (32'(i_RegisterNumber[7:0]) < NUM_VOICES);
    assign ctrl_we  = i_RegisterWriteEnable && (i_RegisterNumber == 16'h0100);
    assign clr_we   = i_RegisterWriteEnable && (i_RegisterNumber == 16'h0101);
    assign gain_idx = i_RegisterNumber[VW-1:0];
    assign gain_val = (i_RegisterValue[8:0] > UNITY) ? UNITY : i_RegisterValue[8:0];

    logic unused_reg_bits;
    assign unused_reg_bits = ^i_RegisterValue[15:9];

    // Gain table is padded to a power of two so any voice index is in range
    logic [8:0] gain [NG];
    logic       mute;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int unsigned i = 0; i < NG; i++) gain[i] <= UNITY;
            mute <= 1'b0;
        end else begin
            if (gain_we) gain[gain_idx] <= gain_val;
            if (ctrl_we) mute <= i_RegisterValue[0];
        end
    end

    // S1: gain multiply
    logic signed [MULT_W-1:0] mult;
    logic signed [PROD_W-1:0] s1_prod;
    logic                     s1_valid;
    logic                     s1_fe;

    assign mult = MULT_W'(i_Subsample) * MULT_W'($signed({1'b0, gain[i_SubsampleVoice]}));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s1_prod  <= '0;
            s1_valid <= 1'b0;
            s1_fe    <= 1'b0;
        end else begin
            s1_prod  <= PROD_W'(mult >>> 8);
            s1_valid <= i_SubsampleValid;
            s1_fe    <= i_SubsampleValid && i_FrameEnd;
        end
    end

    // S2: accumulate, close frame, scale and saturate
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [CMP_W-1:0] scaled;
    logic signed [OUT_W-1:0] sat;
    logic                    sat_hit;
    logic signed [OUT_W-1:0] s2_sample;
    logic                    s2_push;

    always_comb begin
        sum     = acc + ACC_W'(s1_prod);
        scaled  = CMP_W'(sum >>> OUT_SHIFT);
        sat     = OUT_W'(scaled);
        sat_hit = 1'b0;
        if (scaled > SAT_MAX) begin
            sat     = OUT_W'(SAT_MAX);
            sat_hit = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat     = OUT_W'(SAT_MIN);
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            acc       <= '0;
            s2_sample <= '0;
            s2_push   <= 1'b0;
            o_Clipped <= 1'b0;
        end else begin
            s2_push <= s1_fe;
            if (s1_valid) begin
                if (s1_fe) begin
                    acc       <= '0;
                    s2_sample <= mute ? '0 : sat;
                end else begin
                    acc <= sum;
                end
            end
            o_Clipped <= (o_Clipped && !(clr_we && i_RegisterValue[0]))
                         || (s1_fe && !mute && sat_hit);
        end
    end

    // Output FIFO; a push into a full FIFO survives only if the head pops at the same edge
    logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_nxt;
    logic                    pop;
    logic                    full;
    logic                    push_ok;
    logic                    drop;

    assign pop       = o_SampleValid && i_SampleReady;
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push_ok   = s2_push && (!full || pop);
    assign drop      = s2_push && full && !pop;
    assign count_nxt = count + CW'(push_ok) - CW'(pop);
    assign o_Sample  = mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            o_SampleValid <= 1'b0;
            o_Overflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= s2_sample;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count         <= count_nxt;
            o_SampleValid <= (count_nxt != '0);
            o_Overflow    <= (o_Overflow && !(clr_we && i_RegisterValue[1])) || drop;
        end
    end

`ifdef SYNTH_MIXER_READBACK_EN
    // Registered read mux, one cycle behind the address
    logic [15:0] rd_nxt;

    always_comb begin
        rd_nxt = '0;
        if ((i_RegisterNumber[15:8] == 8'h00) && (32'(i_RegisterNumber[7:0]) < NUM_VOICES))
            rd_nxt = 16'(gain[i_RegisterNumber[VW-1:0]]);
        else if (i_RegisterNumber == 16'h0100)
            rd_nxt = {15'b0, mute};
        else if (i_RegisterNumber == 16'h0101)
            rd_nxt = {14'b0, o_Overflow, o_Clipped};
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) o_RegisterReadData <= '0;
        else         o_RegisterReadData <= rd_nxt;
    end
`else
    assign o_RegisterReadData = '0;
`endif

endmodule
